// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults and RAM port FSM encoding for the FIFO controller
// Purpose: default data/address widths and the RAM access state type used by
//          fifo_ram_ctrl.
// Ports:   none (package)
package fifo_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 3;

  // One RAM access per cycle: nothing, a write, or a read.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } ram_state_t;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - write/read pointers, occupancy count and full/empty decode
// Purpose: holds wptr, rptr and count for a 1<<AW entry FIFO. The caller
//          guarantees inc_w and inc_r are never high together.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   inc_w         advance wptr, count+1
//   inc_r         advance rptr, count-1
//   wptr, rptr    slot addresses, wrap modulo 2^AW
//   count         occupancy 0..(1<<AW)
//   full, empty   decoded from count
module fifo_ptr #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_w,
  input  logic          inc_r,
  output logic [AW-1:0] wptr,
  output logic [AW-1:0] rptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
  localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (inc_w) begin
      wptr  <= wptr + PTR_ONE;
      count <= count + CNT_ONE;
    end else if (inc_r) begin
      rptr  <= rptr + PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

  assign full  = (count == DEPTH);
  assign empty = (count == '0);

endmodule

// File: rtl/fifo_ram_ctrl.sv
// rtl/fifo_ram_ctrl.sv - FIFO controller driving an external single-port RAM
// Purpose: arbitrates push/pop requests (round-robin on conflict), issues one
//          registered RAM cycle per accepted request and returns read data two
//          cycles after pop_ack.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   push, push_data, push_ack producer side; push_ack is combinational
//   pop, pop_ack              consumer request/accept; pop_ack is combinational
//   pop_valid, pop_data       read return, pop_data = ram_dout while pop_valid
//   full, empty, count        occupancy status
//   ram_cs_, ram_wr_          RAM chip select / write strobe, active-low, registered
//   ram_addr, ram_din         RAM address and write data, registered
//   ram_dout                  RAM read data, valid the cycle after a read cycle
module fifo_ram_ctrl
  import fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          push_ack,
  input  logic          pop,
  output logic          pop_ack,
  output logic          pop_valid,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          ram_cs_,
  output logic          ram_wr_,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;
  logic          prio;    // 0: push wins a conflict, 1: pop wins
  ram_state_t    state;

  fifo_ptr #(.AW(AW)) u_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_w (push_ack),
    .inc_r (pop_ack),
    .wptr  (wptr),
    .rptr  (rptr),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign push_ack = push_ok & ~(pop_ok & prio);
  assign pop_ack  = pop_ok & ~(push_ok & ~prio);

  // The state register records which access is on the RAM pins this cycle;
  // a RD cycle means ram_dout carries the data in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ram_cs_   <= 1'b1;
      ram_wr_   <= 1'b1;
      ram_addr  <= '0;
      ram_din   <= '0;
      prio      <= 1'b0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= (state == RD);
      if (push_ok && pop_ok) begin
        prio <= ~prio;
      end
      if (push_ack) begin
        state    <= WR;
        ram_cs_  <= 1'b0;
        ram_wr_  <= 1'b0;
        ram_addr <= wptr;
        ram_din  <= push_data;
      end else if (pop_ack) begin
        state    <= RD;
        ram_cs_  <= 1'b0;
        ram_wr_  <= 1'b1;
        ram_addr <= rptr;
      end else begin
        state    <= IDLE;
        ram_cs_  <= 1'b1;
        ram_wr_  <= 1'b1;
      end
    end
  end

  // RAM output is only meaningful on the return cycle; zero otherwise.
  assign pop_data = pop_valid ? ram_dout : '0;

endmodule
